// File: rtl/ascon_share_deser.sv
// Rebuilds NUM_SHARES masked 64-bit shares from PAR-bit-per-share beats, LSB slice first.
// Latency: out_valid rises 1 cycle after the final (or early in_last) beat is accepted.
// Backpressure: no beat is taken while a word waits; in_ready follows out_ready in HOLD.
// Optional build macro: ASCON_DESER_UNMASK_EN adds a registered XOR of all shares (debug only).
module ascon_share_deser #(
    parameter int NUM_SHARES = 11,
    parameter int PAR        = 6,
    parameter int WORD_SIZE  = 64,
    localparam int BEATS     = (WORD_SIZE + PAR - 1) / PAR,
    localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_SHARES*PAR-1:0]       in_data,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_SHARES*WORD_SIZE-1:0] out_shares,
`ifdef ASCON_DESER_UNMASK_EN
    output logic [WORD_SIZE-1:0]            out_unmasked,
`endif
    output logic                            frame_err,
    output logic [CNT_W-1:0]                beat_cnt
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    state_e                          state_q, state_d;
    logic [CNT_W-1:0]                beat_cnt_q, beat_cnt_d;
    logic [NUM_SHARES*WORD_SIZE-1:0] shares_q, shares_d;
    logic                            frame_err_q, frame_err_d;
    logic                            accept;
    logic                            final_beat;

    // Handshake: always ready while collecting; in HOLD a beat may only enter as the word leaves.
    always_comb begin
        in_ready   = (state_q == COLLECT) || out_ready;
        accept     = in_valid && in_ready;
        final_beat = (beat_cnt_q == CNT_W'(BEATS - 1));
    end

    // Next state, beat counter and sticky framing flag; an early in_last closes the word.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        frame_err_d = frame_err_q;
        if (accept) begin
            if (in_last != final_beat) begin
                frame_err_d = 1'b1;
            end
            if (in_last || final_beat) begin
                state_d    = HOLD;
                beat_cnt_d = '0;
            end else begin
                state_d    = COLLECT;
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end else if ((state_q == HOLD) && out_ready) begin
            state_d    = COLLECT;
            beat_cnt_d = '0;
        end
    end

    // Bit placement: word bit k of each share comes from beat k/PAR, slice bit k%PAR.
    // Slice bits that would land past WORD_SIZE on the last beat have no target and drop out.
    always_comb begin
        shares_d = shares_q;
        if (accept) begin
            for (int s = 0; s < NUM_SHARES; s++) begin
                for (int k = 0; k < WORD_SIZE; k++) begin
                    if (beat_cnt_q == CNT_W'(k / PAR)) begin
                        shares_d[s*WORD_SIZE + k] = in_data[s*PAR + (k % PAR)];
                    end
                end
            end
        end
    end

    // State, counter, flag and share registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            beat_cnt_q  <= '0;
            shares_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            shares_q    <= shares_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef ASCON_DESER_UNMASK_EN
    logic [WORD_SIZE-1:0] unmasked_q, unmasked_d;

    // Recombine the next share contents so the debug value lines up with out_shares.
    always_comb begin
        unmasked_d = '0;
        for (int s = 0; s < NUM_SHARES; s++) begin
            unmasked_d = unmasked_d ^ shares_d[s*WORD_SIZE +: WORD_SIZE];
        end
    end

    // Debug recombination register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            unmasked_q <= '0;
        end else begin
            unmasked_q <= unmasked_d;
        end
    end

    assign out_unmasked = unmasked_q;
`endif

    assign out_valid  = (state_q == HOLD);
    assign out_shares = shares_q;
    assign frame_err  = frame_err_q;
    assign beat_cnt   = beat_cnt_q;

endmodule

// File: tb/tb_ascon_share_deser.sv
module tb_ascon_share_deser;
    localparam int NS    = 11;
    localparam int PAR   = 6;
    localparam int WS    = 64;
    localparam int BEATS = 11;
    localparam int CW    = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [NS*PAR-1:0]  in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [NS*WS-1:0]   out_shares;
    logic               frame_err;
    logic [CW-1:0]      beat_cnt;
`ifdef ASCON_DESER_UNMASK_EN
    logic [WS-1:0]      out_unmasked;
`endif

    ascon_share_deser dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_shares (out_shares),
`ifdef ASCON_DESER_UNMASK_EN
        .out_unmasked(out_unmasked),
`endif
        .frame_err  (frame_err),
        .beat_cnt   (beat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NS*WS-1:0] sh;
        logic             ferr;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          stalls = 0;
    int          cyc    = 0;
    bit          rand_rdy = 0;
    logic [63:0] cur_w[NS];   // word being sent
    logic [63:0] mdl[NS];     // expected share register contents
    bit          mferr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [NS*WS-1:0] act, input logic [NS*WS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [NS*WS-1:0] pack_mdl();
        logic [NS*WS-1:0] r;
        for (int s = 0; s < NS; s++) r[s*WS +: WS] = mdl[s];
        return r;
    endfunction

    // Slice of share s for beat j, with junk placed in any slice bits beyond the word.
    task automatic set_inputs(input int j, input bit last, input logic [5:0] junk);
        logic [NS*PAR-1:0] d;
        for (int s = 0; s < NS; s++) begin
            int          vb;
            logic [5:0]  sl;
            logic [5:0]  m;
            vb = WS - j*PAR;
            if (vb > PAR) vb = PAR;
            sl = 6'(cur_w[s] >> (j*PAR));
            if (vb < PAR) begin
                m  = (6'd1 << vb) - 6'd1;
                sl = (sl & m) | (junk & ~m);
            end
            d[s*PAR +: PAR] = sl;
        end
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
    endtask

    task automatic drive_beat(input int j, input bit last, input logic [5:0] junk);
        int n = 0;
        if (rand_rdy) begin
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        set_inputs(j, last, junk);
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            stalls++;
            @(posedge clk); #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        if (!in_ready) begin
            errors++;
            checks++;
            $display("FAIL beat_accept_timeout: beat %0d never accepted, in_ready=%0b required 1", j, in_ready);
        end
        @(posedge clk); #1;
        // Reference: word bit j*PAR+b of share s takes slice bit b, when it exists.
        for (int s = 0; s < NS; s++)
            for (int b = 0; b < PAR; b++)
                if (j*PAR + b < WS) mdl[s][j*PAR + b] = in_data[s*PAR + b];
        if (last != (j == BEATS-1)) mferr = 1;
        if (last || j == BEATS-1) exp_q.push_back('{sh: pack_mdl(), ferr: mferr});
    endtask

    task automatic send_word(input logic [5:0] junk);
        for (int j = 0; j < BEATS; j++) drive_beat(j, j == BEATS-1, junk);
    endtask

    task automatic rand_word();
        for (int s = 0; s < NS; s++) cur_w[s] = {$urandom, $urandom};
    endtask

    // Monitor: every word handed over must match the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        logic [63:0] x;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {{(NS*WS-1){1'b0}}, out_valid}, '0);
            end else begin
                e = exp_q.pop_front();
                chk("word_shares", out_shares, e.sh);
                chk("word_frame_err", {{(NS*WS-1){1'b0}}, frame_err}, {{(NS*WS-1){1'b0}}, e.ferr});
`ifdef ASCON_DESER_UNMASK_EN
                x = '0;
                for (int s = 0; s < NS; s++) x = x ^ e.sh[s*WS +: WS];
                chk("word_unmasked", {{(NS*WS-WS){1'b0}}, out_unmasked}, {{(NS*WS-WS){1'b0}}, x});
`else
                x = '0;
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, finished=0 required 1");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NS*WS-1:0] snap;
        int               t0;
        int               s0;
        int               n;
        logic [63:0]      xr;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        for (int s = 0; s < NS; s++) mdl[s] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", out_valid, '0);
        chk("reset_out_shares", out_shares, '0);
        chk("reset_frame_err", frame_err, '0);
        chk("reset_beat_cnt", beat_cnt, '0);
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single word, latency exactly one cycle.
        for (int s = 0; s < NS; s++) cur_w[s] = '0;
        cur_w[0] = 64'h0123456789ABCDEF;
        for (int j = 0; j < BEATS-1; j++) drive_beat(j, 0, 6'h00);
        chk("t1_no_valid_before_last", out_valid, '0);
        drive_beat(BEATS-1, 1, 6'h00);
        chk("t1_valid_after_1", out_valid, 1);
        chk("t1_share0", out_shares[0 +: WS], 64'h0123456789ABCDEF);
        chk("t1_other_shares", out_shares[NS*WS-1:WS], '0);
        chk("t1_frame_err", frame_err, '0);
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Last-beat masking: all-ones final slices leave only the top 4 bits set.
        for (int s = 0; s < NS; s++) cur_w[s] = 64'hF000000000000000;
        send_word(6'h3f);
        for (int s = 0; s < NS; s++)
            chk("t2_mask_share", out_shares[s*WS +: WS], 64'hF000000000000000);
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Backpressure for 5 cycles with the next beat 0 waiting.
        out_ready = 1'b0;
        rand_word();
        send_word(6'h15);
        snap = pack_mdl();
        rand_word();
        set_inputs(0, 0, 6'h00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_in_ready_low", in_ready, '0);
            chk("t3_shares_stable", out_shares, snap);
            chk("t3_valid_held", out_valid, 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        s0 = stalls;
        drive_beat(0, 0, 6'h00);
        chk("t3_same_cycle_accept_stalls", stalls - s0, 0);
        chk("t3_beat_cnt_1", beat_cnt, 1);
        chk("t3_valid_fell", out_valid, '0);
        for (int j = 1; j < BEATS; j++) drive_beat(j, j == BEATS-1, 6'h2a);

        // Back-to-back: three words in 33 cycles with no stalls.
        s0 = stalls;
        t0 = cyc;
        for (int w = 0; w < 3; w++) begin
            rand_word();
            send_word(6'($urandom));
        end
        chk("t4_no_stalls", stalls - s0, 0);
        chk("t4_cycles", cyc - t0, 33);

        // Framing: in_last on beat 5 closes the word early.
        rand_word();
        for (int j = 0; j <= 5; j++) drive_beat(j, j == 5, 6'h00);
        chk("t5_frame_err", frame_err, 1);
        chk("t5_valid", out_valid, 1);
        chk("t5_beat_cnt", beat_cnt, '0);
        rand_word();
        send_word(6'h00);
        chk("t5_frame_err_sticky", frame_err, 1);

        // Reset in the middle of a word.
        rand_word();
        for (int j = 0; j <= 4; j++) drive_beat(j, 0, 6'h00);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("t6_rst_valid", out_valid, '0);
        chk("t6_rst_shares", out_shares, '0);
        chk("t6_rst_frame_err", frame_err, '0);
        chk("t6_rst_beat_cnt", beat_cnt, '0);
        for (int s = 0; s < NS; s++) mdl[s] = '0;
        mferr = 0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rand_word();
        xr = 64'hDEADBEEFCAFEF00D;
        for (int s = 0; s < NS-1; s++) xr = xr ^ cur_w[s];
        cur_w[NS-1] = xr;
        send_word(6'h00);
        chk("t6_word_after_reset", out_shares, pack_mdl());
`ifdef ASCON_DESER_UNMASK_EN
        chk("t6_unmasked", {{(NS*WS-WS){1'b0}}, out_unmasked}, {{(NS*WS-WS){1'b0}}, 64'hDEADBEEFCAFEF00D});
`endif

        // Random words with random gaps and consumer stalls.
        rand_rdy = 1;
        for (int w = 0; w < 15; w++) begin
            rand_word();
            send_word(6'($urandom));
        end
        rand_rdy = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk("drain_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
